// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_arb_pkg                                     |
// | Description : Shared constants for the register-file access       |
// |               arbiter: FSM state encoding and default widths.     |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package regfile_arb_pkg;

   localparam int c_ADDR_WIDTH = 8;
   localparam int c_DATA_WIDTH = 32;

   typedef logic [1:0] arb_state_t;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_RESP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/regfile_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_rr_pick                                     |
// | Description : Combinational round-robin picker. Searches upward   |
// |               from i_last_grant+1 (wrapping) for the first set    |
// |               request bit.                                        |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module regfile_rr_pick
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_grant,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] w_cand;

   // Walk the requesters in priority order, keeping the first one found.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_any       = 1'b0;
      w_cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((32'(i_last_grant) + 32'(k)) % NUM_REQ);
         if (!o_any && i_req[w_cand]) begin
            o_any           = 1'b1;
            o_grant_idx     = w_cand;
            o_grant[w_cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_access_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_access_arbiter                              |
// | Description : Round-robin sharing of the register-file write port |
// |               and read port among NUM_REQ requesters. Each        |
// |               request takes IDLE(accept) -> ISSUE -> RESP.        |
// |               Optional macro REGFILE_ARB_LOCK_EN adds req_lock    |
// |               for atomic read-modify-write sequences.             |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module regfile_access_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = c_ADDR_WIDTH,
   parameter int DATA_WIDTH = c_DATA_WIDTH,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
`ifdef REGFILE_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*BE_WIDTH-1:0]   req_be,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rf_wr_en,
   output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
   output logic [DATA_WIDTH-1:0]         rf_wr_data,
   output logic [BE_WIDTH-1:0]           rf_wr_be,
   output logic [ADDR_WIDTH-1:0]         rf_rd_addr,
   input  logic [DATA_WIDTH-1:0]         rf_rd_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t             r_state;
   logic [IDX_W-1:0]       r_last_grant;
   logic                   r_write;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [BE_WIDTH-1:0]    r_be;
   logic [DATA_WIDTH-1:0]  r_rdata;

   logic [NUM_REQ-1:0]     w_pick_req;
   logic [NUM_REQ-1:0]     w_grant;
   logic [IDX_W-1:0]       w_grant_idx;
   logic                   w_any;
   logic                   w_accept;
   logic                   w_issue_wr;
   logic                   w_issue_rd;

`ifdef REGFILE_ARB_LOCK_EN
   logic                   r_locked;
   logic [IDX_W-1:0]       r_lock_owner;
   logic [NUM_REQ-1:0]     w_owner_mask;

   // While locked only the owner may compete; everyone else is masked off.
   assign w_owner_mask = NUM_REQ'(1) << r_lock_owner;
   assign w_pick_req   = r_locked ? (req_valid & w_owner_mask) : req_valid;

   // Lock follows the req_lock bit of every accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_locked     <= 1'b0;
         r_lock_owner <= '0;
      end else if (w_accept) begin
         r_locked     <= req_lock[w_grant_idx];
         r_lock_owner <= w_grant_idx;
      end
   end
`else
   assign w_pick_req = req_valid;
`endif

   regfile_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req        (w_pick_req),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_grant_idx  (w_grant_idx),
      .o_any        (w_any)
   );

   // rst_n gates acceptance so req_ready stays low while reset is held.
   assign w_accept   = (r_state == ARB_IDLE) && w_any && rst_n;
   assign req_ready  = w_accept ? w_grant : '0;

   assign w_issue_wr = (r_state == ARB_ISSUE) && r_write;
   assign w_issue_rd = (r_state == ARB_ISSUE) && !r_write;

   assign rf_wr_en   = w_issue_wr;
   assign rf_wr_addr = w_issue_wr ? r_addr  : '0;
   assign rf_wr_data = w_issue_wr ? r_wdata : '0;
   assign rf_wr_be   = w_issue_wr ? r_be    : '0;
   assign rf_rd_addr = w_issue_rd ? r_addr  : '0;

   assign rsp_valid  = (r_state == ARB_RESP) ? (NUM_REQ'(1) << r_last_grant) : '0;
   assign rsp_rdata  = r_rdata;

   // Transaction sequencer: capture the winner, access the file, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ARB_IDLE;
         r_last_grant <= IDX_W'(NUM_REQ - 1);
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_rdata      <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_write      <= req_write[w_grant_idx];
                  r_addr       <= req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  r_wdata      <= req_wdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                  r_be         <= req_be[w_grant_idx*BE_WIDTH +: BE_WIDTH];
                  r_last_grant <= w_grant_idx;
                  r_state      <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               r_rdata <= r_write ? '0 : rf_rd_data;
               r_state <= ARB_RESP;
            end
            ARB_RESP: begin
               r_rdata <= '0;
               r_state <= ARB_IDLE;
            end
            default: begin
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_regfile_access_arbiter                           |
// | Description : Self-checking bench for regfile_access_arbiter with |
// |               a behavioural reference model and a small register  |
// |               file. Lock checks build with REGFILE_ARB_LOCK_EN.   |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_regfile_access_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 8;
   localparam int DW      = 32;
   localparam int BW      = 4;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_write = '0;
`ifdef REGFILE_ARB_LOCK_EN
   logic [NUM_REQ-1:0]    req_lock = '0;
`endif
   logic [NUM_REQ*AW-1:0] req_addr = '0;
   logic [NUM_REQ*DW-1:0] req_wdata = '0;
   logic [NUM_REQ*BW-1:0] req_be = '0;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [DW-1:0]         rsp_rdata;
   logic                  rf_wr_en;
   logic [AW-1:0]         rf_wr_addr;
   logic [DW-1:0]         rf_wr_data;
   logic [BW-1:0]         rf_wr_be;
   logic [AW-1:0]         rf_rd_addr;
   logic [DW-1:0]         rf_rd_data;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   regfile_access_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
`ifdef REGFILE_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rf_wr_be(rf_wr_be), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
   );

   // Register file the arbiter drives: combinational read, byte-masked write.
   logic [DW-1:0] mem [256];
   assign rf_rd_data = mem[rf_rd_addr];
   initial for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0001 + i;
   always @(posedge clk)
      if (rf_wr_en)
         for (int b = 0; b < BW; b++)
            if (rf_wr_be[b]) mem[rf_wr_addr][b*8 +: 8] <= rf_wr_data[b*8 +: 8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A transaction is accepted in cycle A; its file access is expected in
   // cycle A+1 and its response in cycle A+2. Nothing is accepted while a
   // transaction is outstanding.
   int            cyc = 0;
   int            m_last = NUM_REQ - 1;
   bit            m_have = 0;
   int            m_acc, m_w;
   bit            m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data, m_rd_exp;
   logic [BW-1:0] m_be;
   bit            m_locked = 0;
   int            m_owner = 0;
   logic [DW-1:0] shadow [256];
   initial for (int i = 0; i < 256; i++) shadow[i] = 32'hA5A5_0001 + i;

   always @(negedge clk) begin
      logic [NUM_REQ-1:0] e_ready, e_rsp;
      logic               e_wen;
      logic [AW-1:0]      e_waddr, e_raddr;
      logic [DW-1:0]      e_wdata, e_rdata;
      logic [BW-1:0]      e_be;
      bit                 found;
      int                 c;
      e_ready = '0; e_rsp = '0; e_wen = 1'b0; e_waddr = '0; e_raddr = '0;
      e_wdata = '0; e_rdata = '0; e_be = '0; found = 0;
      if (!rst_n) begin
         m_have = 0; m_last = NUM_REQ - 1; m_locked = 0;
      end else if (m_have && cyc == m_acc + 1) begin
         if (m_wr) begin
            e_wen = 1'b1; e_waddr = m_addr; e_wdata = m_data; e_be = m_be;
            for (int b = 0; b < BW; b++)
               if (m_be[b]) shadow[m_addr][b*8 +: 8] = m_data[b*8 +: 8];
         end else begin
            e_raddr = m_addr;
            m_rd_exp = shadow[m_addr];
         end
      end else if (m_have && cyc == m_acc + 2) begin
         e_rsp[m_w] = 1'b1;
         e_rdata = m_wr ? '0 : m_rd_exp;
         m_have = 0;
      end else if (!m_have) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            c = (m_last + k) % NUM_REQ;
            if (!found && req_valid[c] && (!m_locked || c == m_owner)) begin
               found = 1; e_ready[c] = 1'b1; m_have = 1; m_acc = cyc; m_w = c;
               m_wr = req_write[c]; m_addr = req_addr[c*AW +: AW];
               m_data = req_wdata[c*DW +: DW]; m_be = req_be[c*BW +: BW];
               m_last = c;
`ifdef REGFILE_ARB_LOCK_EN
               m_locked = req_lock[c]; m_owner = c;
`endif
            end
         end
      end
      chk("model_req_ready",  req_ready,  e_ready);
      chk("model_rsp_valid",  rsp_valid,  e_rsp);
      chk("model_rsp_rdata",  rsp_rdata,  e_rdata);
      chk("model_rf_wr_en",   rf_wr_en,   e_wen);
      chk("model_rf_wr_addr", rf_wr_addr, e_waddr);
      chk("model_rf_wr_data", rf_wr_data, e_wdata);
      chk("model_rf_wr_be",   rf_wr_be,   e_be);
      chk("model_rf_rd_addr", rf_rd_addr, e_raddr);
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be, input bit lk);
      req_write[i] = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      req_be[i*BW +: BW] = be;
`ifdef REGFILE_ARB_LOCK_EN
      req_lock[i] = lk;
`else
      if (lk) req_be[i*BW +: BW] = be;
`endif
      req_valid[i] = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Wait (bounded) for any grant; returns the winner index or -1.
   task automatic wait_grant(output int idx);
      idx = -1;
      for (int n = 0; n < 40 && idx < 0; n++) begin
         @(negedge clk);
         for (int j = 0; j < NUM_REQ; j++) if (req_ready[j]) idx = j;
      end
      if (idx < 0) chk("grant_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0;
      step(); step();
      rst_n = 1'b1;
   endtask

   initial begin
      int w;
      int order [5];
      longint t_prev, t_now;
      int exp_rr [5];
      int exp_lk [3];
      exp_rr = '{0, 1, 2, 3, 0};
      exp_lk = '{1, 2, 0};

      // Reset: outputs stay zero even with requests pending.
      req_valid = '1;
      step();
      @(negedge clk);
      chk("reset_req_ready", req_ready, 4'b0000);
      chk("reset_rsp_valid", rsp_valid, 4'b0000);
      chk("reset_rf_wr_en", rf_wr_en, 1'b0);
      step();
      req_valid = '0;
      rst_n = 1'b1;

      // Single read by requester 1 at address 0.
      set_req(1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
      @(negedge clk); chk("rd_ready", req_ready, 4'b0010);
      step(); req_valid[1] = 1'b0;
      @(negedge clk); chk("rd_rf_rd_addr", rf_rd_addr, 8'h00); chk("rd_no_wr", rf_wr_en, 1'b0);
      @(negedge clk); chk("rd_rsp_valid", rsp_valid, 4'b0010);
      chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      step();

      // Single write by requester 2, partial byte enables.
      set_req(2, 1'b1, 8'h04, 32'h1234_5678, 4'b0101, 1'b0);
      @(negedge clk); chk("wr_ready", req_ready, 4'b0100);
      step(); req_valid[2] = 1'b0;
      @(negedge clk);
      chk("wr_en", rf_wr_en, 1'b1); chk("wr_addr", rf_wr_addr, 8'h04);
      chk("wr_data", rf_wr_data, 32'h1234_5678); chk("wr_be", rf_wr_be, 4'b0101);
      @(negedge clk);
      chk("wr_rsp_valid", rsp_valid, 4'b0100); chk("wr_rsp_rdata", rsp_rdata, 32'h0);
      chk("wr_single_pulse", rf_wr_en, 1'b0);
      step();

      // All four requesters held valid from reset: order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 8'(8 + i), 32'h0, 4'h0, 1'b0);
      t_prev = 0;
      for (int g = 0; g < 5; g++) begin
         wait_grant(w);
         t_now = $time;
         order[g] = w;
         chk("rr_onehot", $onehot(req_ready), 1'b1);
         if (g > 0) chk("rr_spacing_ns", t_now - t_prev, 64'd30);
         t_prev = t_now;
      end
      step(); req_valid = '0;
      for (int g = 0; g < 5; g++) chk("rr_order", order[g], exp_rr[g]);
      step(); step();

      // Read-after-write across requesters.
      set_req(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
      wait_grant(w); chk("raw_wr_grant", w, 0);
      step(); req_valid[0] = 1'b0;
      step(); step();
      set_req(3, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
      wait_grant(w); chk("raw_rd_grant", w, 3);
      step(); req_valid[3] = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("raw_rsp_valid", rsp_valid, 4'b1000); chk("raw_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      step();

      // Reset during the ISSUE cycle of a write: nothing commits or responds.
      set_req(1, 1'b1, 8'h20, 32'hCAFE_F00D, 4'hF, 1'b0);
      wait_grant(w); chk("mid_rst_grant", w, 1);
      step(); rst_n = 1'b0; req_valid = '0;
      @(negedge clk);
      chk("mid_rst_wr_en", rf_wr_en, 1'b0); chk("mid_rst_wr_data", rf_wr_data, 32'h0);
      chk("mid_rst_rsp", rsp_valid, 4'b0000);
      @(negedge clk); chk("mid_rst_rsp2", rsp_valid, 4'b0000);
      step(); rst_n = 1'b1;
      chk("mid_rst_mem_kept", mem[8'h20], 32'hA5A5_0021);
      set_req(0, 1'b0, 8'h01, 32'h0, 4'h0, 1'b0);
      set_req(3, 1'b0, 8'h02, 32'h0, 4'h0, 1'b0);
      @(negedge clk); chk("post_rst_first", req_ready, 4'b0001);
      step(); req_valid[0] = 1'b0;
      wait_grant(w); chk("post_rst_second", w, 3);
      step(); req_valid[3] = 1'b0;
      step(); step();

`ifdef REGFILE_ARB_LOCK_EN
      // Locked read-modify-write by requester 1 excludes 0 and 2.
      do_reset();
      set_req(1, 1'b0, 8'h30, 32'h0, 4'h0, 1'b1);
      wait_grant(w); chk("lock_first", w, 1);
      step(); req_valid[1] = 1'b0;
      set_req(0, 1'b0, 8'h31, 32'h0, 4'h0, 1'b0);
      set_req(2, 1'b0, 8'h32, 32'h0, 4'h0, 1'b0);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk); chk("lock_hold_no_grant", req_ready, 4'b0000);
      end
      step();
      set_req(1, 1'b1, 8'h30, 32'h55AA_55AA, 4'hF, 1'b0);
      for (int g = 0; g < 3; g++) begin
         wait_grant(w);
         chk("lock_order", w, exp_lk[g]);
         step();
         if (w >= 0) req_valid[w] = 1'b0;
      end
      step(); step();
`endif

      step(); step();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
Shares the single write port and one read port of the generated register file among NUM_REQ requesters (CPU bridge, debug port, DMA, etc.). Round-robin arbitration with a valid/ready request handshake and a per-requester one-cycle response strobe. Sits between the bus-side requesters and the register file, and is the only driver of its wr_*/rd_addr ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, register-file address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending per requester
req_ready  out  NUM_REQ  accept strobe, one-hot or zero
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_be  in  NUM_REQ*BE_WIDTH  packed byte enables
rsp_valid  out  NUM_REQ  one-cycle completion strobe, one-hot or zero
rsp_rdata  out  DATA_WIDTH  read data (shared), valid with rsp_valid
rf_wr_en  out  1  register-file write enable
rf_wr_addr  out  ADDR_WIDTH  register-file write address
rf_wr_data  out  DATA_WIDTH  register-file write data
rf_wr_be  out  BE_WIDTH  register-file byte enables
rf_rd_addr  out  ADDR_WIDTH  register-file read address
rf_rd_data  in  DATA_WIDTH  register-file combinational read data

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All outputs are 0 in reset.
- Reset state: FSM = IDLE; last_grant = NUM_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE, one cycle each in ISSUE and RESP.
- IDLE:
  - If any req_valid is set, pick winner w = first set bit searching from last_grant+1 upward, mod NUM_REQ.
  - Assert req_ready[w] combinationally in that cycle.
  - At the clock edge, capture write/addr/wdata/be of w, set last_grant = w, and go to ISSUE.
  - With no valid, stay in IDLE; req_ready = 0.
- ISSUE, write: rf_wr_en = 1 for exactly this cycle, with captured addr/data/be on rf_wr_*.
- ISSUE, read: rf_rd_addr = captured addr; rf_rd_data is registered at the end of the cycle into rsp_rdata.
- ISSUE, always: rf_wr_en = 0 except during a write ISSUE; rf_rd_addr = 0 outside ISSUE-read.
- RESP:
  - rsp_valid[w] = 1 for one cycle.
  - rsp_rdata = captured read data for a read, 0 for a write.
  - Go to IDLE. rsp_rdata returns to 0 in the next cycle.
- Latency: accept at cycle T, rf access at T+1, rsp_valid at T+2. Throughput is 1 request per 3 cycles.
- Read-after-write: a read accepted after a write completes sees the written value, because the write commits at the ISSUE edge.
- Requesters hold req_valid and their fields until req_ready. If valid drops before acceptance, the arbiter simply never grants it; this is not an error.
- req_valid is ignored outside IDLE. Losers keep waiting; no starvation is possible (bound: NUM_REQ-1 grants).
- Reset mid-operation: return to IDLE immediately, with no rf_wr_en pulse and no rsp_valid. The pending transaction is dropped.
- Byte enables are passed unmodified. A write with be = 0 still pulses rf_wr_en and still responds.

Optional Feature:
REGFILE_ARB_LOCK_EN:
- Defined:
  - Adds input req_lock[NUM_REQ].
  - If the winner's req_lock is 1 at acceptance, the arbiter then grants only that requester (others ignored) until that requester has an accepted request with req_lock = 0.
  - Locked requester with no valid in IDLE: the arbiter waits and grants nobody.
  - Reset clears the lock.
  - Used for atomic read-modify-write.
- Not defined: port absent, pure round-robin.

Decomposition:
- Shared package regfile_arb_pkg holds:
  - FSM state enum (ARB_IDLE, ARB_ISSUE, ARB_RESP)
  - default width constants (ADDR_WIDTH 8, DATA_WIDTH 32)
- Sub-module regfile_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, grant index, any.
  - Instantiated once.

Test Plan:
- Single read, req 1, addr 8'h00, rf_rd_data = 32'hA5A5_0001 -> req_ready[1] at T; rf_rd_addr = 8'h00 at T+1; rsp_valid[1] with rsp_rdata = 32'hA5A5_0001 at T+2.
- Single write, req 2, addr 8'h04, data 32'h1234_5678, be 4'b0101 -> exactly one rf_wr_en pulse at T+1 with those values; rsp_valid[2] with rsp_rdata = 0 at T+2.
- All 4 valid from reset, held -> grant order 0,1,2,3,0, each accept 3 cycles apart; req_ready always one-hot.
- Write 32'hDEAD_BEEF by req 0 then read same addr by req 3 -> read response = 32'hDEAD_BEEF.
- rst_n low during ISSUE of a write -> no rf_wr_en and no rsp_valid; all outputs 0; after release requester 0 is granted first.
- With REGFILE_ARB_LOCK_EN: req 1 lock=1 read, then req 0 and req 2 valid -> only req 1 is granted until its lock=0 write completes; then req 2 then req 0.
